// File: rtl/mac_norm_arbiter_pkg.sv
// Shared types and constants for the MAC normalize/round arbiter slice.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        PACK,
        RESP
    } state_e;

    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;
    localparam int SUM_W        = 19;
    localparam int MANT_W       = 11;
    // Bit position of 1.0 in the accumulator sum.
    localparam int SUM_POINT    = 13;

endpackage

// File: rtl/mac_norm_arbiter_if.sv
// Request/response bundle between MAC lanes, the shared normalizer and write-back.
interface mac_norm_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    import mac_pkg::*;

    logic [N_REQ-1:0]       i_req_valid;
    logic [N_REQ-1:0]       o_req_ready;
    logic [N_REQ*SUM_W-1:0] i_req_sum;
    logic [N_REQ*5-1:0]     i_req_exp;
    logic                   o_rsp_valid;
    logic                   i_rsp_ready;
    logic [ID_W-1:0]        o_rsp_id;
    logic [15:0]            o_rsp_data;
    logic                   o_rsp_ovf;
    logic                   o_rsp_unf;

    modport slave (
        input  i_req_valid, i_req_sum, i_req_exp, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_ovf, o_rsp_unf
    );

    modport master (
        output i_req_valid, i_req_sum, i_req_exp, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_ovf, o_rsp_unf
    );

endinterface

// File: rtl/mac_norm_arbiter_norm.sv
// Normalize/round of a 19-bit two's-complement sum to an 11-bit mantissa
// with leading one, plus exponent shift and rounding carry.
module final_norm_noSUB
    import mac_pkg::*;
(
    input  logic [SUM_W-1:0]  sum,
    output logic [MANT_W-1:0] final_norm_sum_with_leading1,
    output logic [4:0]        signed_exp_diff,
    output logic              exp_carry,
    output logic              sign,
    output logic [50:0]       number
);

    localparam int GRD = SUM_W - MANT_W - 1;

    logic [SUM_W-1:0] mag;
    logic [SUM_W-1:0] norm;
    logic [4:0]       lead;
    logic             round_up;
    logic [MANT_W:0]  mant_rnd;

    assign number = 51'd412;

    always_comb begin
        sign = sum[SUM_W-1];
        mag  = sign ? -sum : sum;
        lead = '0;
        for (int unsigned i = 0; i < SUM_W; i++) begin
            if (mag[i]) lead = 5'(i);
        end
        norm = mag << (5'(SUM_W - 1) - lead);
        // Round to nearest, ties to even, on the bits below the mantissa.
        round_up = norm[GRD] & ((|norm[GRD-1:0]) | norm[GRD+1]);
        mant_rnd = {1'b0, norm[SUM_W-1 -: MANT_W]} + {{MANT_W{1'b0}}, round_up};
        exp_carry = mant_rnd[MANT_W];
        final_norm_sum_with_leading1 = exp_carry ? {1'b1, {(MANT_W-1){1'b0}}}
                                                 : mant_rnd[MANT_W-1:0];
        signed_exp_diff = lead - 5'(SUM_POINT);
    end

endmodule

// File: rtl/mac_norm_arbiter.sv
// Round-robin arbiter sharing one normalizer among N_REQ MAC lanes.
// Optional MAC_NORM_STATS_EN builds saturating overflow/underflow counters.
module mac_norm_arbiter
    import mac_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    mac_norm_arbiter_if.slave  bus,
    output logic [15:0]        o_ovf_cnt,
    output logic [15:0]        o_unf_cnt,
    output logic [50:0]        number
);

    state_e state_q, state_d;

    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [SUM_W-1:0]  sum_q;
    logic [4:0]        exp_q;
    logic [ID_W-1:0]   grant_id;
    logic              grant_any;
    logic              accept;
    int unsigned       cand;

    logic [MANT_W-1:0] n_mant, mant_q;
    logic [4:0]        n_diff, diff_q;
    logic              n_carry, carry_q;
    logic              n_sign, sign_q;

    logic signed [6:0] e_d;
    logic [15:0]       data_d;
    logic              ovf_d, unf_d;

    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [15:0]       rsp_data_q;
    logic              ovf_q, unf_q;

    final_norm_noSUB u_norm (
        .sum                          (sum_q),
        .final_norm_sum_with_leading1 (n_mant),
        .signed_exp_diff              (n_diff),
        .exp_carry                    (n_carry),
        .sign                         (n_sign),
        .number                       (number)
    );

    // First valid lane searching upward from rr_ptr+1, wrapping at N_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % 32'(N_REQ);
            if (!grant_any && bus.i_req_valid[ID_W'(cand)]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(cand);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = NORM;
            NORM:    state_d = PACK;
            PACK:    state_d = RESP;
            RESP:    if (bus.i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_req_ready = '0;
        accept          = 1'b0;
        if (state_q == IDLE && grant_any) begin
            bus.o_req_ready[grant_id] = 1'b1;
            accept                    = 1'b1;
        end
    end

    always_comb begin
        e_d = $signed({2'b00, exp_q}) + $signed({{2{diff_q[4]}}, diff_q})
            + $signed({6'b0, carry_q});
        data_d = {sign_q, 15'b0};
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (!mant_q[MANT_W-1]) begin
            data_d = {sign_q, 15'b0};
        end else if (e_d >= $signed(7'(FP16_EXP_MAX))) begin
            data_d = {sign_q, 5'h1F, 10'h0};
            ovf_d  = 1'b1;
        end else if (e_d <= 7'sd0) begin
            unf_d  = 1'b1;
        end else begin
            data_d = {sign_q, e_d[4:0], mant_q[MANT_W-2:0]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q    <= ID_W'(N_REQ - 1);
            id_q        <= '0;
            sum_q       <= '0;
            exp_q       <= '0;
            mant_q      <= '0;
            diff_q      <= '0;
            carry_q     <= 1'b0;
            sign_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            if (accept) begin
                sum_q    <= bus.i_req_sum[SUM_W*grant_id +: SUM_W];
                exp_q    <= bus.i_req_exp[5*grant_id +: 5];
                id_q     <= grant_id;
                rr_ptr_q <= grant_id;
            end
            if (state_q == NORM) begin
                mant_q  <= n_mant;
                diff_q  <= n_diff;
                carry_q <= n_carry;
                sign_q  <= n_sign;
            end
            if (state_q == PACK) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_data_q  <= data_d;
                ovf_q       <= ovf_d;
                unf_q       <= unf_d;
            end else if (state_q == RESP && bus.i_rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_id    = rsp_id_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_ovf   = ovf_q;
    assign bus.o_rsp_unf   = unf_q;

`ifdef MAC_NORM_STATS_EN
    logic [15:0] ovf_cnt_q, unf_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else if (state_q == PACK) begin
            if (ovf_d && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 16'd1;
            if (unf_d && unf_cnt_q != '1) unf_cnt_q <= unf_cnt_q + 16'd1;
        end
    end

    assign o_ovf_cnt = ovf_cnt_q;
    assign o_unf_cnt = unf_cnt_q;
`else
    assign o_ovf_cnt = '0;
    assign o_unf_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_norm_arbiter.sv
// Directed bench for mac_norm_arbiter: grant order, FP16 packing, flags, stall, reset.
module tb_mac_norm_arbiter;
    import mac_pkg::*;

    localparam int N = 4;
    localparam logic [4:0] E15 = 5'(FP16_BIAS);
`ifdef MAC_NORM_STATS_EN
    localparam logic STATS = 1'b1;
`else
    localparam logic STATS = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ovf_cnt, unf_cnt;
    logic [50:0] number;
    int          n_checks = 0;
    int          n_errors = 0;

    mac_norm_arbiter_if #(.N_REQ(N), .ID_W(2)) bus ();

    mac_norm_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bus),
        .o_ovf_cnt (ovf_cnt),
        .o_unf_cnt (unf_cnt),
        .number    (number)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/rsp_valid"}, {31'b0, bus.o_rsp_valid}, 32'd0);
        check({tag, "/req_ready"}, {28'b0, bus.o_req_ready}, 32'd0);
        check({tag, "/rsp_id"},    {30'b0, bus.o_rsp_id},    32'd0);
        check({tag, "/rsp_data"},  {16'b0, bus.o_rsp_data},  32'd0);
        check({tag, "/ovf"},       {31'b0, bus.o_rsp_ovf},   32'd0);
        check({tag, "/unf"},       {31'b0, bus.o_rsp_unf},   32'd0);
        check({tag, "/ovf_cnt"},   {16'b0, ovf_cnt},         32'd0);
        check({tag, "/unf_cnt"},   {16'b0, unf_cnt},         32'd0);
    endtask

    task automatic wait_grant(input int lane);
        int cyc;
        cyc = 0;
        while (bus.o_req_ready[lane] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (bus.o_rsp_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One full transaction on 'lane'; 'extra' lanes are raised alongside it.
    task automatic run_op(input string tag, input int lane, input logic [3:0] extra,
                          input logic [18:0] sum, input logic [4:0] ex,
                          input logic [15:0] edata, input logic eovf, input logic eunf);
        int lat;
        logic [3:0] onehot;
        onehot = 4'b0001 << lane;
        @(negedge clk);
        bus.i_req_sum[lane*19 +: 19] = sum;
        bus.i_req_exp[lane*5 +: 5]   = ex;
        bus.i_req_valid              = extra;
        bus.i_req_valid[lane]        = 1'b1;
        #1;
        wait_grant(lane);
        check({tag, "/grant"}, {28'b0, bus.o_req_ready}, {28'b0, onehot});
        @(negedge clk);
        bus.i_req_valid = '0;
        wait_rsp(lat);
        check({tag, "/latency"}, 32'(lat), 32'd3);
        check({tag, "/data"}, {16'b0, bus.o_rsp_data}, {16'b0, edata});
        check({tag, "/id"},   {30'b0, bus.o_rsp_id},   32'(lane));
        check({tag, "/ovf"},  {31'b0, bus.o_rsp_ovf},  {31'b0, eovf});
        check({tag, "/unf"},  {31'b0, bus.o_rsp_unf},  {31'b0, eunf});
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        check({tag, "/valid_drop"}, {31'b0, bus.o_rsp_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        int n, t;
        int tm[4];
        logic [1:0] exp_ids[4];
        exp_ids = '{2'd0, 2'd2, 2'd0, 2'd2};

        bus.i_req_valid = '0;
        bus.i_req_sum   = '0;
        bus.i_req_exp   = '0;
        bus.i_rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // Basic conversions
        run_op("t1_one",   0, 4'b0, 19'h02000, E15, 16'h3C00, 1'b0, 1'b0);
        run_op("t2_neg",   1, 4'b0, 19'h7E000, E15, 16'hBC00, 1'b0, 1'b0);
        run_op("t2_big",   1, 4'b0, 19'h20000, E15, 16'h4C00, 1'b0, 1'b0);
        run_op("t2_round", 1, 4'b0, 19'h03FFE, E15, 16'h4000, 1'b0, 1'b0);

        // Overflow / underflow with counters
        run_op("t3_ovf", 3, 4'b0, 19'h20000, 5'd28, 16'h7C00, 1'b1, 1'b0);
        check("t3_ovf/ovf_cnt", {16'b0, ovf_cnt}, {31'b0, STATS});
        check("t3_ovf/unf_cnt", {16'b0, unf_cnt}, 32'd0);
        run_op("t3_unf", 2, 4'b0, 19'h00008, 5'd5, 16'h0000, 1'b0, 1'b1);
        check("t3_unf/ovf_cnt", {16'b0, ovf_cnt}, {31'b0, STATS});
        check("t3_unf/unf_cnt", {16'b0, unf_cnt}, {31'b0, STATS});

        // Lanes 0 and 2 continuously valid, back-to-back responses (rr_ptr now 2)
        @(negedge clk);
        bus.i_req_sum[0 +: 19]  = 19'h0;
        bus.i_req_sum[38 +: 19] = 19'h0;
        bus.i_req_exp[0 +: 5]   = E15;
        bus.i_req_exp[10 +: 5]  = E15;
        bus.i_req_valid = 4'b0101;
        bus.i_rsp_ready = 1'b1;
        n = 0;
        t = 0;
        while (n < 4 && t < 40) begin
            @(negedge clk);
            t++;
            if (bus.o_rsp_valid === 1'b1) begin
                tm[n] = t;
                check("t4/id",   {30'b0, bus.o_rsp_id},   {30'b0, exp_ids[n]});
                check("t4/data", {16'b0, bus.o_rsp_data}, 32'd0);
                check("t4/flags", {30'b0, bus.o_rsp_ovf, bus.o_rsp_unf}, 32'd0);
                if (n > 0) check("t4/gap", 32'(tm[n] - tm[n-1]), 32'd4);
                n++;
            end
        end
        check("t4/count", 32'(n), 32'd4);
        bus.i_req_valid = '0;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;

        // Response stall with another lane waiting
        @(negedge clk);
        bus.i_req_sum[57 +: 19] = 19'h02000;
        bus.i_req_exp[15 +: 5]  = E15;
        bus.i_req_valid = 4'b1000;
        #1;
        wait_grant(3);
        check("t5/grant3", {28'b0, bus.o_req_ready}, 32'h8);
        @(negedge clk);
        bus.i_req_sum[19 +: 19] = 19'h20000;
        bus.i_req_exp[5 +: 5]   = E15;
        bus.i_req_valid = 4'b0010;
        wait_rsp(lat);
        check("t5/latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("t5/hold_valid", {31'b0, bus.o_rsp_valid}, 32'd1);
            check("t5/hold_data",  {16'b0, bus.o_rsp_data},  32'h3C00);
            check("t5/hold_id",    {30'b0, bus.o_rsp_id},    32'd3);
            check("t5/hold_flags", {30'b0, bus.o_rsp_ovf, bus.o_rsp_unf}, 32'd0);
            check("t5/hold_ready", {28'b0, bus.o_req_ready}, 32'd0);
            @(negedge clk);
        end
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        #1;
        check("t5/after_valid", {31'b0, bus.o_rsp_valid}, 32'd0);
        check("t5/next_grant",  {28'b0, bus.o_req_ready}, 32'h2);
        @(negedge clk);
        bus.i_req_valid = '0;
        wait_rsp(lat);
        check("t5/l1_latency", 32'(lat), 32'd3);
        check("t5/l1_data", {16'b0, bus.o_rsp_data}, 32'h4C00);
        check("t5/l1_id",   {30'b0, bus.o_rsp_id},   32'd1);
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;

        // Reset asserted while the lane-2 op sits in PACK
        @(negedge clk);
        bus.i_req_sum[38 +: 19] = 19'h20000;
        bus.i_req_exp[10 +: 5]  = 5'd28;
        bus.i_req_valid = 4'b0100;
        #1;
        wait_grant(2);
        check("t6/grant2", {28'b0, bus.o_req_ready}, 32'h4);
        @(negedge clk);
        bus.i_req_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("t6_midrst");
        @(negedge clk);
        @(negedge clk);
        check("t6/no_valid", {31'b0, bus.o_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        bus.i_req_sum[57 +: 19] = 19'h02000;
        bus.i_req_exp[15 +: 5]  = E15;
        run_op("t6_fresh", 0, 4'b1000, 19'h20000, 5'd28, 16'h7C00, 1'b1, 1'b0);
        check("t6/ovf_cnt", {16'b0, ovf_cnt}, {31'b0, STATS});
        check("t6/unf_cnt", {16'b0, unf_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_norm_arbiter.md
# mac_norm_arbiter

- Shares one `final_norm_noSUB` normalize/round unit among `N_REQ` MAC lanes.
- Arbitrates round-robin, registers the winning 19-bit accumulator sum and 5-bit biased exponent, and drives them through the normalizer.
- Applies the exponent adjustment and overflow/underflow handling, then returns a packed FP16 result on one shared response channel.
- Sits between the per-lane accumulators and the MAC subsystem write-back.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesting lanes (2..8).
- `ID_W`, default 2: lane-index width, equal to clog2(`N_REQ`).

Ports:
- `i_clk`  in  1: clock. One clock; all flops on the rising edge.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_req_valid`  in  `N_REQ`: per-lane request valid.
- `o_req_ready`  out  `N_REQ`: per-lane accept. One-hot or zero.
- `i_req_sum`  in  `N_REQ`*19: flattened two's-complement sums. Lane k is at [19k+18:19k].
- `i_req_exp`  in  `N_REQ`*5: flattened biased exponents, bias 15.
- `o_rsp_valid`  out  1: response valid.
- `i_rsp_ready`  in  1: response accept.
- `o_rsp_id`  out  `ID_W`: lane that produced the response.
- `o_rsp_data`  out  16: FP16 result {sign, exp[4:0], mant[9:0]}.
- `o_rsp_ovf`  out  1: overflow flag, valid with `o_rsp_valid`.
- `o_rsp_unf`  out  1: underflow flag, valid with `o_rsp_valid`.
- `o_ovf_cnt`  out  16: overflow event count. See Configuration.
- `o_unf_cnt`  out  16: underflow event count.
- `number`  out  51: gate count, forwarded from the normalizer instance.

## Operation
FSM states: IDLE, NORM, PACK, RESP.
- **IDLE**
  - If any `i_req_valid` is set, grant the first valid lane starting at `rr_ptr+1` (mod `N_REQ`).
  - `o_req_ready` for the granted lane is driven combinationally in IDLE only.
  - On the handshake: latch sum, exp and id; set `rr_ptr` to the granted id; go to NORM.
- **NORM**
  - The latched sum drives the normalizer.
  - Register `final_norm_sum_with_leading1`, `signed_exp_diff`, `exp_carry` and `sign`.
  - Go to PACK.
- **PACK**
  - e = exp + sext(`signed_exp_diff`) + `exp_carry`, computed in 7-bit signed.
  - Zero: if mant[10]==0, the result is {sign,15'b0}, no flags.
  - Overflow: else if e≥31, the result is {sign,5'h1F,10'h0}, `ovf`=1.
  - Underflow: else if e≤0, the result is {sign,15'b0}, `unf`=1 (flush; no subnormals).
  - Otherwise the result is {sign,e[4:0],mant[9:0]}.
  - Register the response fields; go to RESP.
- **RESP**
  - `o_rsp_valid`=1; all response fields held stable.
  - On `i_rsp_ready`, go to IDLE.
  - No new grant in the same cycle as the response handshake.

Boundary conditions:
- `rr_ptr` resets to `N_REQ`-1, so lane 0 wins first. It wraps modulo `N_REQ`.
- A lane never granted while its valid is low; valid dropping before grant is legal.
- Reset asserted mid-transaction: the in-flight op is discarded. The FSM goes to IDLE with `o_rsp_valid`=0 and no counter update.

## Timing
- Accept in cycle t (IDLE) → `o_rsp_valid` rises at t+3.
- Peak throughput: one result per 4 cycles with `i_rsp_ready` held high.
- Reset values:
  - FSM=IDLE; `o_req_ready`=0; `o_rsp_valid`=0.
  - `o_rsp_id`=0, `o_rsp_data`=0, `o_rsp_ovf`=0, `o_rsp_unf`=0.
  - `o_ovf_cnt`=0, `o_unf_cnt`=0.
- Every output except `o_req_ready` and `number` is driven from a register.

## Configuration
- Macro: `MAC_NORM_STATS_EN`.
- Defined:
  - `o_ovf_cnt` and `o_unf_cnt` count the PACK→RESP transitions that carry `ovf`/`unf`.
  - Both counters saturate at 16'hFFFF and are cleared only by reset.
- Undefined:
  - The counter flops are not built; both ports tie to 0.
  - All other behaviour is unchanged.

## Structure
- Shared package `mac_pkg` holds:
  - FSM state enum.
  - FP16 constants: `FP16_BIAS`=15, `FP16_EXP_MAX`=31.
  - Sum width 19 and mantissa width 11.
- One sub-module: an instance of `final_norm_noSUB`, fed from the latched sum register.
- Round-robin grant stays inline.

## Test plan
1. Lane 0: sum=19'h02000, exp=15 → `o_rsp_data`=16'h3C00, id 0, no flags, valid exactly 3 cycles after accept.
2. Lane 1: sum=19'h7E000 (negative) exp=15 → 16'hBC00. Sum=19'h20000 exp=15 → 16'h4C00. Sum=19'h03FFE exp=15 (rounding carry) → 16'h4000.
3. Overflow and underflow:
   - Sum=19'h20000, exp=28 → 16'h7C00, `o_rsp_ovf`=1.
   - Sum=19'h00008, exp=5 → 16'h0000, `o_rsp_unf`=1.
   - With `MAC_NORM_STATS_EN`: `o_ovf_cnt`=1 and `o_unf_cnt`=1 after each; both stay 0 without the macro.
4. Lanes 0 and 2 valid continuously, `i_rsp_ready`=1 → ids 0,2,0,2, each response 4 cycles apart. Sum=0 gives 16'h0000 with no flags.
5. Hold `i_rsp_ready`=0 for 5 cycles in RESP → data, id and flags stable and no `o_req_ready` asserted. Release → next grant one cycle after the handshake.
6. Assert `i_rst_n`=0 in PACK → all outputs reset asynchronously. After release, lane 0 wins first and a fresh transaction completes normally.
